bitstream_to_byte: RTL and testbench
====================================

# bitstream_to_byte

Serial-to-parallel receiver, the receive-side counterpart of `byte_to_bitstream`. It hunts the incoming qualified bitstream for a sync byte, then assembles the following bits MSB-first into bytes and emits a fixed number of bytes per frame before hunting again. It sits between the bit-level demodulator/decision stage and the byte-oriented framing/packet logic.

## Interface
- `SYNC_WORD`, 8'h7E: byte pattern that marks frame start.
- `FRAME_BYTES`, 4: payload bytes emitted per frame after sync; legal range 1..255.
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-low.
- `data_in` input, 1 bit: serial bit, sampled only when `data_in_valid`=1.
- `data_in_valid` input, 1 bit: qualifies `data_in`; may drop for any number of cycles between bits.
- `data_out` output, 8 bits: assembled byte; first received bit lands in bit 7.
- `data_out_valid` output, 1 bit: one-cycle pulse, `data_out` valid.
- `locked` output, 1 bit: high from the sync match until the last payload byte has been emitted.

## Operation
- State machine with two states, HUNT and LOCKED. The reset state is HUNT.
- Reset (`rst`=0 at an edge):
  - state HUNT, all shift registers 0, all counters 0.
  - `data_out`=0, `data_out_valid`=0, `locked`=0.
  - Applies mid-frame as well: the partial byte is discarded and no pulse is emitted.
- Cycles with `data_in_valid`=0 change nothing except clearing `data_out_valid`.
- HUNT:
  - Each valid bit shifts into an 8-bit hunt register: `hunt <= {hunt[6:0], data_in}`.
  - A 4-bit fill counter counts valid bits since entering HUNT and saturates at 8.
  - Match condition: `{hunt[6:0], data_in} == SYNC_WORD` and at least 7 bits are already held. This prevents a false match on the cleared register, including when SYNC_WORD is 0.
  - On a match: go to LOCKED, set `locked`=1, clear the bit and byte counters.
- LOCKED:
  - Each valid bit shifts into the assembly register: `asm <= {asm[6:0], data_in}`.
  - A 3-bit bit counter increments and wraps 7 -> 0.
  - When a valid bit arrives with bit counter = 7:
    - `data_out <= {asm[6:0], data_in}` and `data_out_valid <= 1`.
    - The byte counter increments.
    - If byte counter = FRAME_BYTES-1: go to HUNT, clear `locked`, the hunt register and the fill counter.
- Hunting restarts only after a frame completes. Payload bytes equal to SYNC_WORD are passed through as data.
- `data_out` holds its last value between pulses.

## Timing
- Latency: the 8th bit of a byte is sampled at edge N; `data_out_valid`=1 and `data_out` are valid for the cycle after edge N, and `data_out_valid`=0 after edge N+1.
- Consecutive bytes with no gaps give one pulse every 8 cycles. The minimum pulse spacing is 8 cycles.
- `locked` rises at the edge that samples the last sync bit.
- `locked` falls at the same edge that registers the final byte, so `locked`=0 during the final `data_out_valid` pulse.
- The first payload bit may arrive in the cycle immediately after the sync match.
- There is no backpressure. The consumer must accept every pulse.

## Structure
- Shared package `bitstream_pkg`:
  - `BYTE_W`=8.
  - State typedef `rx_state_t` {HUNT, LOCKED}.
  - Default `SYNC_WORD` constant, shared with the transmitter-side framer.
- One sub-module is natural: `sipo_shift8`, an 8-bit serial-in/parallel-out register with a shift enable and a synchronous clear. It is instantiated twice, once for the hunt register and once for the assembly register.
- The FSM and counters live in the top module.

## Test plan
- Reset, then 8'h7E, 8'hAA, 8'h0F, 8'h00, 8'hFF sent MSB-first with `data_in_valid` held high -> `locked` high after the 8th bit; four pulses with `data_out` 8'hAA, 8'h0F, 8'h00, 8'hFF, spaced 8 cycles apart; `locked`=0 on the last pulse.
- Same frame with `data_in_valid` low for 3 cycles between every bit -> same bytes, each pulse one cycle after its 8th valid bit.
- Bits 0,1,1,1,1,1,1,0 appearing only across a misaligned boundary (e.g. leading bits 1,0 then 0x7E) -> sync found at the true alignment; garbage bits before it produce no pulses.
- SYNC_WORD=8'h00, reset, then five zero bits -> no lock. Three more zero bits (8 total) -> `locked`=1.
- Reset asserted low for one cycle after 5 payload bits of byte 2 -> no pulse; `locked`=0 and `data_out`=0 the next cycle; the FSM re-hunts and locks on a fresh 8'h7E.
- Payload byte 8'h7E inside a frame -> emitted as data; the byte count stays unaffected and the frame ends after FRAME_BYTES bytes.

Source files
------------

// File: rtl/bitstream_pkg.sv
// Shared definitions for the bitstream framer/deframer pair.
package bitstream_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } rx_state_t;

   localparam logic [BYTE_W-1:0] DEFAULT_SYNC_WORD = 8'h7E;

endpackage

// File: rtl/sipo_shift8.sv
// 8-bit serial-in/parallel-out view: stores the last seven bits and presents them
// with the incoming bit appended, so a completed byte is visible in the cycle it finishes.
module sipo_shift8
   import bitstream_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic [BYTE_W-1:0] q
);

   logic [BYTE_W-2:0] hold_reg;

   assign q = {hold_reg, din};

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_reg <= '0;
      end else if (clr) begin
         hold_reg <= '0;
      end else if (en) begin
         hold_reg <= q[BYTE_W-2:0];
      end
   end

endmodule

// File: rtl/bitstream_to_byte.sv
// Serial-to-parallel receiver: hunts for SYNC_WORD, then emits FRAME_BYTES
// MSB-first bytes before hunting again.
module bitstream_to_byte
   import bitstream_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
   parameter int                FRAME_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_in,
   input  logic              data_in_valid,
   output logic [BYTE_W-1:0] data_out,
   output logic              data_out_valid,
   output logic              locked
);

   localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

   rx_state_t         state_reg, state_next;
   logic [3:0]        fill_cnt_reg;
   logic [2:0]        bit_cnt_reg;
   logic [7:0]        byte_cnt_reg;
   logic [BYTE_W-1:0] data_out_reg;
   logic              data_out_valid_reg;

   logic [BYTE_W-1:0] hunt_word, asm_word;
   logic              hunt_en, asm_en;
   logic              sync_match, byte_done, frame_done;

   assign hunt_en = data_in_valid && (state_reg == HUNT);
   assign asm_en  = data_in_valid && (state_reg == LOCKED);

   sipo_shift8 u_hunt (
      .clk (clk),
      .rst (rst),
      .clr (frame_done),
      .en  (hunt_en),
      .din (data_in),
      .q   (hunt_word)
   );

   sipo_shift8 u_asm (
      .clk (clk),
      .rst (rst),
      .clr (sync_match),
      .en  (asm_en),
      .din (data_in),
      .q   (asm_word)
   );

   always_comb begin
      state_next = state_reg;
      sync_match = 1'b0;
      byte_done  = 1'b0;
      frame_done = 1'b0;
      case (state_reg)
         HUNT: begin
            // fill check stops a match against the cleared register
            if (data_in_valid && (fill_cnt_reg >= 4'd7) && (hunt_word == SYNC_WORD)) begin
               sync_match = 1'b1;
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (data_in_valid && (bit_cnt_reg == 3'd7)) begin
               byte_done = 1'b1;
               if (byte_cnt_reg == LAST_BYTE) begin
                  frame_done = 1'b1;
                  state_next = HUNT;
               end
            end
         end
         default: state_next = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg          <= HUNT;
         fill_cnt_reg       <= '0;
         bit_cnt_reg        <= '0;
         byte_cnt_reg       <= '0;
         data_out_reg       <= '0;
         data_out_valid_reg <= 1'b0;
      end else begin
         state_reg          <= state_next;
         data_out_valid_reg <= byte_done;
         if (byte_done) begin
            data_out_reg <= asm_word;
         end
         if (frame_done) begin
            fill_cnt_reg <= '0;
         end else if (hunt_en && (fill_cnt_reg < 4'd8)) begin
            fill_cnt_reg <= fill_cnt_reg + 4'd1;
         end
         if (sync_match) begin
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
         end else if (asm_en) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (byte_done) begin
               byte_cnt_reg <= byte_cnt_reg + 8'd1;
            end
         end
      end
   end

   assign data_out       = data_out_reg;
   assign data_out_valid = data_out_valid_reg;
   assign locked         = (state_reg == LOCKED);

endmodule

// File: tb/tb_bitstream_to_byte.sv
// Directed bench for bitstream_to_byte: default sync word plus a SYNC_WORD=0 instance.
module tb_bitstream_to_byte;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       data_in = 1'b0;
   logic       data_in_valid = 1'b0;
   logic [7:0] data_out, data_out_z;
   logic       data_out_valid, data_out_valid_z;
   logic       locked, locked_z;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int stamps[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_out_valid) begin
         pulse_cnt = pulse_cnt + 1;
         stamps.push_back(cyc);
      end
   end

   bitstream_to_byte #(.SYNC_WORD(8'h7E), .FRAME_BYTES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .locked         (locked)
   );

   bitstream_to_byte #(.SYNC_WORD(8'h00), .FRAME_BYTES(4)) dut_zero (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out_z),
      .data_out_valid (data_out_valid_z),
      .locked         (locked_z)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      data_in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      data_in_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      data_in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Sends a byte MSB-first with `gap` idle cycles after each bit; when chk is
   // set, checks the pulse right after the 8th bit and its clearing one cycle later.
   task automatic send_byte(input string tag, input logic [7:0] b, input int gap,
                            input bit chk, input logic exp_lock);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i == 0 && chk) begin
            check_val({tag, " valid"}, 32'(data_out_valid), 32'd1);
            check_val({tag, " data"}, 32'(data_out), 32'(b));
            check_val({tag, " locked"}, 32'(locked), 32'(exp_lock));
         end
         for (int g = 0; g < gap; g++) begin
            idle(1);
            if (i == 0 && chk && g == 0)
               check_val({tag, " valid drop"}, 32'(data_out_valid), 32'd0);
         end
      end
   endtask

   initial begin
      logic [7:0] garbage;
      @(negedge clk);
      do_reset();

      // reset state
      check_val("rst data_out", 32'(data_out), 32'h0);
      check_val("rst valid", 32'(data_out_valid), 32'd0);
      check_val("rst locked", 32'(locked), 32'd0);

      // back-to-back frame
      stamps.delete();
      for (int i = 7; i >= 1; i--) send_bit(1'((8'h7E >> i) & 8'h01));
      check_val("t1 locked before last sync bit", 32'(locked), 32'd0);
      send_bit(1'b0);
      check_val("t1 locked after sync", 32'(locked), 32'd1);
      send_byte("t1 b0", 8'hAA, 0, 1'b1, 1'b1);
      send_byte("t1 b1", 8'h0F, 0, 1'b1, 1'b1);
      send_byte("t1 b2", 8'h00, 0, 1'b1, 1'b1);
      send_byte("t1 b3", 8'hFF, 0, 1'b1, 1'b0);
      idle(4);
      check_val("t1 pulse count", 32'(stamps.size()), 32'd4);
      if (stamps.size() == 4) begin
         for (int k = 1; k < 4; k++)
            check_val("t1 spacing", 32'(stamps[k] - stamps[k-1]), 32'd8);
      end
      check_val("t1 data hold", 32'(data_out), 32'hFF);
      check_val("t1 valid idle", 32'(data_out_valid), 32'd0);

      // same frame with 3 idle cycles between bits
      send_byte("t2 sync", 8'h7E, 3, 1'b0, 1'b1);
      check_val("t2 locked", 32'(locked), 32'd1);
      send_byte("t2 b0", 8'hAA, 3, 1'b1, 1'b1);
      send_byte("t2 b1", 8'h0F, 3, 1'b1, 1'b1);
      send_byte("t2 b2", 8'h00, 3, 1'b1, 1'b1);
      send_byte("t2 b3", 8'hFF, 3, 1'b1, 1'b0);

      // misaligned sync preceded by garbage bits 1,0
      do_reset();
      pulse_cnt = 0;
      send_bit(1'b1);
      send_bit(1'b0);
      garbage = 8'h7E;
      for (int i = 7; i >= 1; i--) send_bit(garbage[i]);
      check_val("t3 no early lock", 32'(locked), 32'd0);
      send_bit(garbage[0]);
      check_val("t3 locked", 32'(locked), 32'd1);
      check_val("t3 no garbage pulses", 32'(pulse_cnt), 32'd0);
      send_byte("t3 b0", 8'h3C, 0, 1'b1, 1'b1);
      send_byte("t3 b1", 8'hC3, 0, 1'b1, 1'b1);
      send_byte("t3 b2", 8'h81, 0, 1'b1, 1'b1);
      send_byte("t3 b3", 8'h5A, 0, 1'b1, 1'b0);

      // SYNC_WORD = 0 instance: needs 8 zero bits
      do_reset();
      repeat (5) send_bit(1'b0);
      check_val("t4 no lock after 5 zeros", 32'(locked_z), 32'd0);
      repeat (2) send_bit(1'b0);
      check_val("t4 no lock after 7 zeros", 32'(locked_z), 32'd0);
      send_bit(1'b0);
      check_val("t4 lock after 8 zeros", 32'(locked_z), 32'd1);

      // reset mid-frame
      do_reset();
      pulse_cnt = 0;
      send_byte("t5 sync", 8'h7E, 0, 1'b0, 1'b1);
      send_byte("t5 b0", 8'hAA, 0, 1'b1, 1'b1);
      garbage = 8'h0F;
      for (int i = 7; i >= 3; i--) send_bit(garbage[i]);
      do_reset();
      check_val("t5 valid after reset", 32'(data_out_valid), 32'd0);
      check_val("t5 locked after reset", 32'(locked), 32'd0);
      check_val("t5 data after reset", 32'(data_out), 32'h0);
      check_val("t5 pulse count", 32'(pulse_cnt), 32'd1);
      send_byte("t5 resync", 8'h7E, 0, 1'b0, 1'b1);
      check_val("t5 relocked", 32'(locked), 32'd1);
      send_byte("t5 r0", 8'h11, 0, 1'b1, 1'b1);
      send_byte("t5 r1", 8'h22, 0, 1'b1, 1'b1);
      send_byte("t5 r2", 8'h33, 0, 1'b1, 1'b1);
      send_byte("t5 r3", 8'h44, 0, 1'b1, 1'b0);

      // sync pattern inside payload is plain data
      send_byte("t6 sync", 8'h7E, 0, 1'b0, 1'b1);
      send_byte("t6 b0", 8'h7E, 0, 1'b1, 1'b1);
      send_byte("t6 b1", 8'h12, 0, 1'b1, 1'b1);
      send_byte("t6 b2", 8'h7E, 0, 1'b1, 1'b1);
      send_byte("t6 b3", 8'h34, 0, 1'b1, 1'b0);
      idle(2);
      check_val("t6 unlocked after frame", 32'(locked), 32'd0);
      send_byte("t6 next sync", 8'h7E, 0, 1'b0, 1'b1);
      check_val("t6 rehunt lock", 32'(locked), 32'd1);

      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
